// File: rtl/mat_mul_arbiter_if.sv
// Handshake bundle between the mat_mul arbiter and its requesters / engine.
//   req           requester -> arbiter   per-requester job request (level)
//   gnt           arbiter -> requester   one-hot grant for the whole job
//   done / err    arbiter -> requester   one-cycle completion / timeout pulse
//   sel           arbiter -> datapath    owner index for operand/result muxes
//   eng_start     arbiter -> engine      one-cycle start pulse
//   eng_out_valid engine -> arbiter      result valid
//   eng_out_ready arbiter -> engine      result accept (RUN only)
interface mat_mul_arbiter_if #(
   parameter int NUM_REQ = 4
);
   localparam int SEL_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [NUM_REQ-1:0] req;
   logic [NUM_REQ-1:0] gnt;
   logic [NUM_REQ-1:0] done;
   logic [NUM_REQ-1:0] err;
   logic [SEL_W-1:0]   sel;
   logic               eng_start;
   logic               eng_out_valid;
   logic               eng_out_ready;

   // arbiter side
   modport slave (
      input  req, eng_out_valid,
      output gnt, done, err, sel, eng_start, eng_out_ready
   );

   // requester / engine side
   modport master (
      output req, eng_out_valid,
      input  gnt, done, err, sel, eng_start, eng_out_ready
   );
endinterface

// File: rtl/mat_mul_arbiter.sv
// Round-robin scheduler sharing one mat_mul engine between NUM_REQ requesters.
// One job at a time: grant, start pulse, wait for the engine result (or timeout),
// then a done/err pulse to the owner. Also keeps latency / job-count counters.
//   clk_i           system clock, rising edge
//   rst_ni          asynchronous active-low reset
//   bus             handshake bundle (slave modport)
//   busy_o          high whenever a job is in flight (state != IDLE)
//   last_latency_o  cycles of the last successful job, START through handshake
//   job_count_o     successful jobs, wraps
module mat_mul_arbiter #(
   parameter int NUM_REQ        = 4,
   parameter int TIMEOUT_CYCLES = 64,
   parameter int CNT_WIDTH      = 32
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   mat_mul_arbiter_if.slave     bus,
   output logic                 busy_o,
   output logic [CNT_WIDTH-1:0] last_latency_o,
   output logic [CNT_WIDTH-1:0] job_count_o
);
   localparam int SEL_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_RUN,
      S_DONE,
      S_ERR
   } state_e;

   state_e               state_q, state_d;
   logic [SEL_W-1:0]     sel_q, sel_d;
   logic [SEL_W-1:0]     ptr_q, ptr_d;
   logic [CNT_WIDTH-1:0] lat_q, lat_d;
   logic [CNT_WIDTH-1:0] last_lat_q, last_lat_d;
   logic [CNT_WIDTH-1:0] jobs_q, jobs_d;

   logic                 pick_vld;
   logic [SEL_W-1:0]     pick_idx;
   logic [CNT_WIDTH-1:0] lat_inc;
   logic [NUM_REQ-1:0]   sel_oh;

   // Round-robin pick: scan ptr+1, ptr+2, ... Iterating from the far end
   // lets the nearest set bit be the last (winning) assignment.
   always_comb begin
      pick_vld = 1'b0;
      pick_idx = '0;
      for (int i = NUM_REQ; i >= 1; i--) begin
         if (bus.req[SEL_W'((int'(ptr_q) + i) % NUM_REQ)]) begin
            pick_vld = 1'b1;
            pick_idx = SEL_W'((int'(ptr_q) + i) % NUM_REQ);
         end
      end
   end

   // lat_inc is the number of cycles elapsed since START including the
   // current one; the timeout test uses it so the job is cut off after
   // exactly TIMEOUT_CYCLES cycles, and a valid in that last cycle still wins.
   assign lat_inc = (&lat_q) ? lat_q : lat_q + 1'b1;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= S_IDLE;
         sel_q      <= '0;
         ptr_q      <= SEL_W'(NUM_REQ - 1);
         lat_q      <= '0;
         last_lat_q <= '0;
         jobs_q     <= '0;
      end else begin
         state_q    <= state_d;
         sel_q      <= sel_d;
         ptr_q      <= ptr_d;
         lat_q      <= lat_d;
         last_lat_q <= last_lat_d;
         jobs_q     <= jobs_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      sel_d      = sel_q;
      ptr_d      = ptr_q;
      lat_d      = lat_q;
      last_lat_d = last_lat_q;
      jobs_d     = jobs_q;
      unique case (state_q)
         S_IDLE: begin
            if (pick_vld) begin
               sel_d   = pick_idx;
               state_d = S_START;
            end
         end
         S_START: begin
            lat_d   = CNT_WIDTH'(1);
            state_d = S_RUN;
         end
         S_RUN: begin
            lat_d = lat_inc;
            if (bus.eng_out_valid)                             state_d = S_DONE;
            else if (lat_inc == CNT_WIDTH'(TIMEOUT_CYCLES))     state_d = S_ERR;
         end
         S_DONE: begin
            last_lat_d = lat_q;
            jobs_d     = jobs_q + 1'b1;
            ptr_d      = sel_q;
            state_d    = S_IDLE;
         end
         S_ERR: begin
            ptr_d   = sel_q;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs are decoded from registered state only, so an async reset
   // clears every one of them immediately.
   assign sel_oh            = {{(NUM_REQ-1){1'b0}}, 1'b1} << sel_q;
   assign busy_o            = (state_q != S_IDLE);
   assign bus.gnt           = busy_o ? sel_oh : '0;
   assign bus.done          = (state_q == S_DONE) ? sel_oh : '0;
   assign bus.err           = (state_q == S_ERR) ? sel_oh : '0;
   assign bus.sel           = sel_q;
   assign bus.eng_start     = (state_q == S_START);
   assign bus.eng_out_ready = (state_q == S_RUN);
   assign last_latency_o    = last_lat_q;
   assign job_count_o       = jobs_q;
endmodule
